// File: rtl/store_monitor_pkg.sv
// Shared types and helpers for the processor store monitor.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CYC_W  = 16;
  localparam int LOG_ENTRY_W = DEF_ADDR_W + DEF_DATA_W + DEF_CYC_W;

  function automatic int log_entry_w(input int addr_w, input int data_w, input int cyc_w);
    return addr_w + data_w + cyc_w;
  endfunction

  // Counter increment that holds at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head; pointers carry a wrap bit.
module sync_fifo #(
  parameter int WIDTH      = 80,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic [WIDTH-1:0]    r_dout;
  logic [DEPTH_LOG2:0] w_rd_nxt;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                    (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_pop    = pop && !w_empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_push   = push && (!w_full || w_pop);
  assign w_rd_nxt = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end
  end

  // The head register is kept equal to the oldest entry so dout never depends on a memory read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      if (w_empty) begin
        if (w_push) r_dout <= din;
      end else if (w_pop) begin
        if (w_rd_nxt == r_wr_ptr) begin
          if (w_push) r_dout <= din;
        end else begin
          r_dout <= r_mem[w_rd_nxt[DEPTH_LOG2-1:0]];
        end
      end
    end
  end

  assign full  = w_full;
  assign empty = w_empty;
  assign dout  = r_dout;

endmodule

// File: rtl/store_monitor.sv
// Watches the processor data-memory write port: pass/fail/timeout detection,
// timestamped store log and saturating store/drop counters.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter int                LOG_DEPTH_LOG2 = 4,
  parameter int                CYC_W          = 16,
  parameter logic [ADDR_W-1:0] PASS_ADDR      = 32'd100,
  parameter logic [DATA_W-1:0] PASS_DATA      = 32'd25,
  parameter int                TIMEOUT        = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_data,
  output logic [CYC_W-1:0]  log_cycle,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [15:0]       store_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int               ENTRY_W = log_entry_w(ADDR_W, DATA_W, CYC_W);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);

  state_t             r_state;
  logic [CYC_W-1:0]   r_cyc_cnt;
  logic [15:0]        r_store_cnt;
  logic [7:0]         r_drop_cnt;
  logic               r_done;
  logic               r_pass;
  logic               r_fail;
  logic               r_timeout;

  logic               w_store;
  logic               w_term;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_dout;

  assign w_store = (r_state == ST_RUN) && MemWrite && !clear;
  assign w_term  = w_store && (DataAdr == PASS_ADDR);
  assign w_pop   = log_ready && !w_empty;
  assign w_drop  = w_store && w_full && !w_pop;
  assign w_din   = {DataAdr, WriteData, r_cyc_cnt};

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (LOG_DEPTH_LOG2)
  ) u_log_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .push  (w_store),
    .din   (w_din),
    .full  (w_full),
    .pop   (log_ready),
    .dout  (w_dout),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_cyc_cnt   <= '0;
      r_store_cnt <= '0;
      r_drop_cnt  <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_RUN;
      r_cyc_cnt   <= '0;
      r_store_cnt <= '0;
      r_drop_cnt  <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_cyc_cnt <= r_cyc_cnt + 1'b1;
          if (w_store) r_store_cnt <= 16'(sat_inc(32'(r_store_cnt), 32'h0000_FFFF));
          if (w_drop)  r_drop_cnt  <= 8'(sat_inc(32'(r_drop_cnt), 32'h0000_00FF));
          // A signature store in the watchdog's last cycle takes precedence.
          if (w_term) begin
            r_done <= 1'b1;
            if (WriteData == PASS_DATA) begin
              r_state <= ST_PASS;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end
          end else if (r_cyc_cnt == CYC_LAST) begin
            r_state   <= ST_TIMEOUT;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign log_valid = !w_empty;
  assign log_addr  = w_dout[ENTRY_W-1 -: ADDR_W];
  assign log_data  = w_dout[CYC_W +: DATA_W];
  assign log_cycle = w_dout[CYC_W-1:0];
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timeout   = r_timeout;
  assign store_cnt = r_store_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor with a 4-entry log and a 20-cycle watchdog.
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic [15:0] log_cycle;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [15:0] store_cnt;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_monitor #(
    .DATA_W         (32),
    .ADDR_W         (32),
    .LOG_DEPTH_LOG2 (2),
    .CYC_W          (16),
    .PASS_ADDR      (32'd100),
    .PASS_DATA      (32'd25),
    .TIMEOUT        (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .log_valid (log_valid),
    .log_ready (log_ready),
    .log_addr  (log_addr),
    .log_data  (log_data),
    .log_cycle (log_cycle),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout),
    .store_cnt (store_cnt),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; MemWrite = 1'b0;
    DataAdr = '0; WriteData = '0; log_ready = 1'b0;
    tick(); tick();
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_pass",      32'(pass),      32'd0);
    chk("rst_timeout",   32'(timeout),   32'd0);
    chk("rst_log_valid", 32'(log_valid), 32'd0);
    chk("rst_store_cnt", 32'(store_cnt), 32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);

    // Watchdog: no stores, flag appears after the 20th edge.
    reset = 1'b1;
    repeat (19) tick();
    chk("to_before", 32'(timeout), 32'd0);
    tick();
    chk("to_timeout",   32'(timeout),   32'd1);
    chk("to_done",      32'(done),      32'd1);
    chk("to_pass",      32'(pass),      32'd0);
    chk("to_fail",      32'(fail),      32'd0);
    chk("to_store_cnt", 32'(store_cnt), 32'd0);

    // Pass signature after one ordinary store.
    do_clear();
    store(32'h60, 32'd7);
    chk("ps_valid", 32'(log_valid), 32'd1);
    store(32'd100, 32'd25);
    chk("ps_pass",      32'(pass),      32'd1);
    chk("ps_done",      32'(done),      32'd1);
    chk("ps_timeout",   32'(timeout),   32'd0);
    chk("ps_store_cnt", 32'(store_cnt), 32'd2);
    chk("ps_h0_addr",   log_addr,       32'h60);
    chk("ps_h0_data",   log_data,       32'd7);
    chk("ps_h0_cyc",    32'(log_cycle), 32'd0);
    log_ready = 1'b1;
    tick();
    chk("ps_h1_addr", log_addr,       32'd100);
    chk("ps_h1_data", log_data,       32'd25);
    chk("ps_h1_cyc",  32'(log_cycle), 32'd1);
    tick();
    chk("ps_drained", 32'(log_valid), 32'd0);
    log_ready = 1'b0;

    // Wrong signature data, then a later correct one is ignored.
    do_clear();
    store(32'd100, 32'd24);
    chk("fl_fail",      32'(fail),      32'd1);
    chk("fl_store_cnt", 32'(store_cnt), 32'd1);
    store(32'd100, 32'd25);
    chk("fl_fail_hold", 32'(fail),      32'd1);
    chk("fl_pass",      32'(pass),      32'd0);
    chk("fl_store_hold",32'(store_cnt), 32'd1);

    // Overflow: six stores into four slots.
    do_clear();
    for (int i = 0; i < 6; i++) store(32'h10 + 32'(i), 32'(i));
    chk("ov_store_cnt", 32'(store_cnt), 32'd6);
    chk("ov_drop_cnt",  32'(drop_cnt),  32'd2);
    log_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ov_head%0d", i), log_data, 32'(i));
      tick();
    end
    chk("ov_empty", 32'(log_valid), 32'd0);
    log_ready = 1'b0;

    // Overflow with a pop coinciding with the fifth store.
    do_clear();
    for (int i = 0; i < 4; i++) store(32'h10 + 32'(i), 32'(i));
    log_ready = 1'b1;
    store(32'h14, 32'd4);
    log_ready = 1'b0;
    store(32'h15, 32'd5);
    chk("ovp_store_cnt", 32'(store_cnt), 32'd6);
    chk("ovp_drop_cnt",  32'(drop_cnt),  32'd1);
    log_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("ovp_head%0d", i), log_data, 32'(i));
      tick();
    end
    chk("ovp_empty", 32'(log_valid), 32'd0);
    log_ready = 1'b0;

    // Signature store in the watchdog's final cycle.
    do_clear();
    repeat (19) tick();
    chk("race_before", 32'(timeout), 32'd0);
    store(32'd100, 32'd25);
    chk("race_pass",    32'(pass),      32'd1);
    chk("race_timeout", 32'(timeout),   32'd0);
    chk("race_cyc",     32'(log_cycle), 32'd19);

    // Clear from PASS with three entries; the clear-cycle store is discarded.
    do_clear();
    store(32'h20, 32'd1);
    store(32'h24, 32'd2);
    store(32'd100, 32'd25);
    chk("cl_pre_pass", 32'(pass),      32'd1);
    chk("cl_pre_cnt",  32'(store_cnt), 32'd3);
    MemWrite = 1'b1; DataAdr = 32'h30; WriteData = 32'd9;
    do_clear();
    MemWrite = 1'b0;
    chk("cl_pass",  32'(pass),      32'd0);
    chk("cl_done",  32'(done),      32'd0);
    chk("cl_valid", 32'(log_valid), 32'd0);
    chk("cl_cnt",   32'(store_cnt), 32'd0);
    chk("cl_drop",  32'(drop_cnt),  32'd0);

    // Asynchronous reset mid-cycle.
    store(32'h40, 32'd1);
    store(32'h44, 32'd2);
    chk("ar_pre_cnt", 32'(store_cnt), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(log_valid), 32'd0);
    chk("ar_cnt",   32'(store_cnt), 32'd0);
    chk("ar_done",  32'(done),      32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("ar_run_valid", 32'(log_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
